// File: rtl/dit_trace_comparator.sv
// Dual-copy control trace comparator.
// Two copies of a control trace are compared lane by lane on each valid
// sample. After a warm-up of WARMUP valid samples the comparator arms. On
// the first differing sample it latches which lanes differed, the cycle
// count at that moment and both traces, and then stays failed until
// rst or clear.
module dit_trace_comparator #(
  parameter int WIDTH  = 16,
  parameter int LANES  = 4,
  parameter int WARMUP = 2,
  parameter int CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   valid,
  input  logic                   clear,
  input  logic [LANES-1:0]       lane_en,
  input  logic [LANES*WIDTH-1:0] trace_a,
  input  logic [LANES*WIDTH-1:0] trace_b,
  output logic                   armed,
  output logic                   mismatch,
  output logic [LANES-1:0]       mismatch_lanes,
  output logic [CNT_W-1:0]       cycle_cnt,
  output logic [CNT_W-1:0]       first_cycle,
  output logic [LANES*WIDTH-1:0] snap_a,
  output logic [LANES*WIDTH-1:0] snap_b
);

  localparam logic [1:0] ST_WARM   = 2'd0;
  localparam logic [1:0] ST_ARMED  = 2'd1;
  localparam logic [1:0] ST_FAILED = 2'd2;

  // With no warm-up requested the comparator comes out of reset armed.
  localparam logic [1:0] ST_INIT   = (WARMUP == 0) ? ST_ARMED : ST_WARM;
  // Warm counter value on the last ignored sample.
  localparam logic [7:0] WARM_LAST = (WARMUP == 0) ? 8'd0 : 8'(WARMUP - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0]             state_q, state_d;
  logic [7:0]             warm_q, warm_d;
  logic                   armed_q, armed_d;
  logic                   mismatch_q, mismatch_d;
  logic [LANES-1:0]       lanes_q, lanes_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]       first_q, first_d;
  logic [LANES*WIDTH-1:0] snap_a_q, snap_a_d;
  logic [LANES*WIDTH-1:0] snap_b_q, snap_b_d;
  logic [LANES-1:0]       diff;

  // Per-lane difference, masked by the lane enables.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    diff = '0;
    for (int k = 0; k < LANES; k++) begin
      diff[k] = lane_en[k] & (trace_a[k*WIDTH +: WIDTH] != trace_b[k*WIDTH +: WIDTH]);
    end
  end

  // Next-state logic; nothing moves on a cycle without a valid sample.
  always_comb begin
    state_d  = state_q;
    warm_d   = warm_q;
    lanes_d  = lanes_q;
    cnt_d    = cnt_q;
    first_d  = first_q;
    snap_a_d = snap_a_q;
    snap_b_d = snap_b_q;
    if (valid) begin
      case (state_q)
        ST_WARM: begin
          warm_d = warm_q + 8'd1;
          if (warm_q == WARM_LAST) state_d = ST_ARMED;
        end
        ST_ARMED: begin
          if (|diff) begin
            state_d  = ST_FAILED;
            lanes_d  = diff;
            first_d  = cnt_q;
            snap_a_d = trace_a;
            snap_b_d = trace_b;
          end
        end
        ST_FAILED: state_d = ST_FAILED;
        default:   state_d = ST_INIT;
      endcase
      if ((state_q == ST_ARMED || state_q == ST_FAILED) && cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    armed_d    = (state_d == ST_ARMED) || (state_d == ST_FAILED);
    mismatch_d = (state_d == ST_FAILED);
  end

  // State and output registers; rst and clear both restart everything.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values, independent of statement order.
    if (rst || clear) begin
      state_q    <= ST_INIT;
      warm_q     <= '0;
      armed_q    <= (WARMUP == 0);
      mismatch_q <= 1'b0;
      lanes_q    <= '0;
      cnt_q      <= '0;
      first_q    <= '0;
      snap_a_q   <= '0;
      snap_b_q   <= '0;
    end else begin
      state_q    <= state_d;
      warm_q     <= warm_d;
      armed_q    <= armed_d;
      mismatch_q <= mismatch_d;
      lanes_q    <= lanes_d;
      cnt_q      <= cnt_d;
      first_q    <= first_d;
      snap_a_q   <= snap_a_d;
      snap_b_q   <= snap_b_d;
    end
  end

  assign armed          = armed_q;
  assign mismatch       = mismatch_q;
  assign mismatch_lanes = lanes_q;
  assign cycle_cnt      = cnt_q;
  assign first_cycle    = first_q;
  assign snap_a         = snap_a_q;
  assign snap_b         = snap_b_q;

endmodule

// File: tb/tb_dit_trace_comparator.sv
// Bench for dit_trace_comparator: two instances share stimulus, one with
// default parameters and one with WARMUP=0, CNT_W=4. Each driven cycle
// advances a behavioural model per instance and queues the expected
// outputs; a monitor pops and compares them after every rising edge.
module tb_dit_trace_comparator;

  localparam int W = 16;
  localparam int L = 4;
  localparam int N = W * L;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, clear, valid;
  logic [L-1:0] lane_en;
  logic [N-1:0] trace_a, trace_b;

  logic         d1_armed, d1_mism, d2_armed, d2_mism;
  logic [L-1:0] d1_lanes, d2_lanes;
  logic [15:0]  d1_cnt, d1_first;
  logic [3:0]   d2_cnt, d2_first;
  logic [N-1:0] d1_sa, d1_sb, d2_sa, d2_sb;

  dit_trace_comparator #(.WIDTH(W), .LANES(L), .WARMUP(2), .CNT_W(16)) u_dut1 (
    .clk(clk), .rst(rst), .valid(valid), .clear(clear), .lane_en(lane_en),
    .trace_a(trace_a), .trace_b(trace_b), .armed(d1_armed), .mismatch(d1_mism),
    .mismatch_lanes(d1_lanes), .cycle_cnt(d1_cnt), .first_cycle(d1_first),
    .snap_a(d1_sa), .snap_b(d1_sb)
  );

  dit_trace_comparator #(.WIDTH(W), .LANES(L), .WARMUP(0), .CNT_W(4)) u_dut2 (
    .clk(clk), .rst(rst), .valid(valid), .clear(clear), .lane_en(lane_en),
    .trace_a(trace_a), .trace_b(trace_b), .armed(d2_armed), .mismatch(d2_mism),
    .mismatch_lanes(d2_lanes), .cycle_cnt(d2_cnt), .first_cycle(d2_first),
    .snap_a(d2_sa), .snap_b(d2_sb)
  );

  typedef struct {
    int           seen;
    bit           armed;
    bit           failed;
    int           cnt;
    int           first;
    logic [L-1:0] lanes;
    logic [N-1:0] sa;
    logic [N-1:0] sb;
  } mdl_t;

  typedef struct {
    mdl_t e1;
    mdl_t e2;
  } pair_t;

  mdl_t  m1, m2;
  pair_t sb_q[$];
  int    vectors = 0;
  int    fails   = 0;

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @%0t: got %h, want %h", name, $time, act, exp);
    end
  endtask

  // Reference behaviour: count valid samples until warm-up is satisfied,
  // then compare; the first difference freezes the capture fields.
  task automatic model_step(inout mdl_t m, input int warmup, input int cnt_max,
                            input bit r, input bit c, input bit v,
                            input logic [L-1:0] en, input logic [N-1:0] a, input logic [N-1:0] b);
    logic [L-1:0] d;
    if (r || c) begin
      m.seen = 0; m.armed = (warmup == 0); m.failed = 0;
      m.cnt = 0; m.first = 0; m.lanes = '0; m.sa = '0; m.sb = '0;
    end else if (v) begin
      if (!m.armed) begin
        m.seen++;
        if (m.seen >= warmup) m.armed = 1;
      end else begin
        d = '0;
        for (int k = 0; k < L; k++)
          if (en[k] && a[k*W +: W] != b[k*W +: W]) d[k] = 1'b1;
        if (!m.failed && d != 0) begin
          m.failed = 1; m.lanes = d; m.first = m.cnt; m.sa = a; m.sb = b;
        end
        m.cnt = (m.cnt + 1 > cnt_max) ? cnt_max : m.cnt + 1;
      end
    end
  endtask

  // Drive one cycle at the falling edge, queue its expected result, and
  // return at the next falling edge with DUT outputs settled.
  task automatic step(input bit r, input bit c, input bit v, input logic [L-1:0] en,
                      input logic [N-1:0] a, input logic [N-1:0] b);
    pair_t p;
    rst = r; clear = c; valid = v; lane_en = en; trace_a = a; trace_b = b;
    model_step(m1, 2, 65535, r, c, v, en, a, b);
    model_step(m2, 0, 15, r, c, v, en, a, b);
    p.e1 = m1;
    p.e2 = m2;
    sb_q.push_back(p);
    @(negedge clk);
  endtask

  function automatic logic [N-1:0] rep(input logic [W-1:0] v);
    return {L{v}};
  endfunction

  function automatic logic [N-1:0] flip(input logic [N-1:0] base, input int lane, input logic [W-1:0] mask);
    logic [N-1:0] t;
    t = base;
    t[lane*W +: W] = t[lane*W +: W] ^ mask;
    return t;
  endfunction

  // Monitor: one expected entry per clock edge driven by step().
  initial begin
    pair_t p;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        p = sb_q.pop_front();
        check("d1_armed", N'(d1_armed), N'(p.e1.armed));
        check("d1_mismatch", N'(d1_mism), N'(p.e1.failed));
        check("d1_lanes", N'(d1_lanes), N'(p.e1.lanes));
        check("d1_cycle_cnt", N'(d1_cnt), N'(p.e1.cnt));
        check("d1_first_cycle", N'(d1_first), N'(p.e1.first));
        check("d1_snap_a", d1_sa, p.e1.sa);
        check("d1_snap_b", d1_sb, p.e1.sb);
        check("d2_armed", N'(d2_armed), N'(p.e2.armed));
        check("d2_mismatch", N'(d2_mism), N'(p.e2.failed));
        check("d2_lanes", N'(d2_lanes), N'(p.e2.lanes));
        check("d2_cycle_cnt", N'(d2_cnt), N'(p.e2.cnt));
        check("d2_first_cycle", N'(d2_first), N'(p.e2.first));
        check("d2_snap_a", d2_sa, p.e2.sa);
        check("d2_snap_b", d2_sb, p.e2.sb);
      end
    end
  end

  initial begin
    logic [N-1:0] a, b;
    logic [W-1:0] msk;
    rst = 1'b1; clear = 1'b0; valid = 1'b0; lane_en = '1; trace_a = '0; trace_b = '0;
    @(negedge clk);

    // Warm-up then clean comparison.
    a = rep(16'h1234);
    step(1, 0, 0, 4'hF, '0, '0);
    check("rst_armed_d1", N'(d1_armed), 0);
    check("rst_armed_d2_nowarm", N'(d2_armed), 1);
    check("rst_cnt_d1", N'(d1_cnt), 0);
    for (int i = 0; i < 10; i++) step(0, 0, 1, 4'hF, a, a);
    check("warm_armed", N'(d1_armed), 1);
    check("warm_mismatch", N'(d1_mism), 0);
    check("warm_cnt8", N'(d1_cnt), 8);

    // First mismatch on lane 2 at cycle_cnt 5.
    step(1, 0, 0, 4'hF, '0, '0);
    for (int i = 0; i < 7; i++) step(0, 0, 1, 4'hF, a, a);
    check("pre_fail_cnt5", N'(d1_cnt), 5);
    step(0, 0, 1, 4'hF, a, flip(a, 2, 16'h0001));
    check("fail_mismatch", N'(d1_mism), 1);
    check("fail_lanes", N'(d1_lanes), 4'b0100);
    check("fail_first", N'(d1_first), 5);
    check("fail_snap_b_l2", N'(d1_sb[47:32]), 16'h1235);
    check("fail_snap_a_l2", N'(d1_sa[47:32]), 16'h1234);

    // A later mismatch leaves the captures alone.
    step(0, 0, 1, 4'hF, a, flip(a, 0, 16'h8000));
    check("sticky_lanes", N'(d1_lanes), 4'b0100);
    check("sticky_first", N'(d1_first), 5);
    check("sticky_cnt", N'(d1_cnt), 7);

    // Clear wins over a simultaneous mismatch, then re-arm.
    step(0, 1, 1, 4'hF, a, flip(a, 1, 16'h00F0));
    check("clr_mismatch", N'(d1_mism), 0);
    check("clr_armed", N'(d1_armed), 0);
    check("clr_snap_b", d1_sb, '0);
    check("clr_first", N'(d1_first), 0);
    step(0, 0, 1, 4'hF, a, a);
    check("rearm_1", N'(d1_armed), 0);
    step(0, 0, 1, 4'hF, a, a);
    check("rearm_2", N'(d1_armed), 1);

    // Disabled lane differences are ignored.
    step(1, 0, 0, 4'hF, '0, '0);
    for (int i = 0; i < 2; i++) step(0, 0, 1, 4'b1011, a, a);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 4'b1011, a, flip(a, 2, 16'h0101));
    check("en_masked", N'(d1_mism), 0);
    b = flip(flip(a, 2, 16'h0101), 0, 16'h0002);
    step(0, 0, 1, 4'b1011, a, b);
    check("en_lane0", N'(d1_mism), 1);
    check("en_lanes", N'(d1_lanes), 4'b0001);

    // Counter saturation on the narrow instance, with idle gaps.
    step(1, 0, 0, 4'hF, '0, '0);
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 1, 4'hF, a, a);
      step(0, 0, 0, 4'hF, a, flip(a, 3, 16'hFFFF));
    end
    check("sat_cnt15", N'(d2_cnt), 15);
    check("sat_no_fail", N'(d2_mism), 0);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      a = {$urandom, $urandom};
      b = a;
      if ($urandom_range(9) == 0) begin
        msk = W'(1) << $urandom_range(W - 1);
        b = flip(b, int'($urandom_range(L - 1)), msk);
        if ($urandom_range(2) == 0) b = flip(b, int'($urandom_range(L - 1)), 16'h0400);
      end
      step($urandom_range(79) == 0, $urandom_range(39) == 0, $urandom_range(3) != 0,
           L'($urandom), a, b);
    end

    // Final edge's entry was popped by the monitor before this falling edge.
    check("queue_drained", N'(sb_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
